// File: rtl/serial_alu_ctrl.sv
// Bit-serial 32-bit ALU with a valid/ready handshake: one result bit per clock, LSB first.
// Optional zero flag output enabled by defining SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        c_out
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        c_out_q, c_out_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic        zero_q, zero_d;
`endif

  logic bit_a, bit_b, bit_g, bit_p, bit_s, bit_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      carry_q  <= 1'b0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 3'b000;
      result_q <= 32'h0;
      c_out_q  <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One full-adder slice per clock; the counter saturates at 31 instead of wrapping.
  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    c_out_d  = c_out_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif

    bit_a = a_q[cnt_q];
    bit_b = b_q[cnt_q] ^ op_q[2];
    bit_g = bit_a & bit_b;
    bit_p = bit_a | bit_b;
    bit_s = bit_a ^ bit_b ^ carry_q;
    case (op_q[1:0])
      2'b00:   bit_r = bit_g;
      2'b01:   bit_r = bit_p;
      2'b10:   bit_r = bit_s;
      default: bit_r = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = alu_op;
          cnt_d   = 5'd0;
          carry_d = alu_op[2];
        end
      end
      BUSY: begin
        result_d[cnt_q] = bit_r;
        carry_d         = bit_g | (bit_p & carry_q);
        if (cnt_q != 5'd31) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          // Set-less-than uses the raw sign of the difference, no overflow fix-up.
          if (op_q[1:0] == 2'b11) result_d[0] = bit_s;
          c_out_d = carry_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
          zero_d  = (result_d == 32'h0);
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    c_out     = c_out_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    zero      = zero_q;
`endif
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl; zero flag checks follow SERIAL_ALU_ZERO_FLAG_EN.
module tb_serial_alu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        c_out;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic        zero;
`endif

  int passed = 0;
  int total  = 0;

  serial_alu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation and returns at the first negedge where out_valid is seen (or timeout).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [2:0] top,
                        output int lat, output logic busy_rdy);
    @(negedge clk);
    a = ta; b = tbv; alu_op = top; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; alu_op = 3'($urandom);
    lat = 0;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 100) begin
      busy_rdy |= in_ready;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [2:0] top, input logic [31:0] exp_res, input logic exp_c);
    int lat;
    logic busy_rdy;
    run_op(ta, tbv, top, lat, busy_rdy);
    total++;
    if (lat !== 32) $display("[TB] FAIL %s latency: got %0d expected 32", name, lat);
    else passed++;
    total++;
    if (busy_rdy !== 1'b0) $display("[TB] FAIL %s in_ready_busy: got %b expected 0", name, busy_rdy);
    else passed++;
    total++;
    if (result !== exp_res) $display("[TB] FAIL %s result: got %h expected %h", name, result, exp_res);
    else passed++;
    total++;
    if (c_out !== exp_c) $display("[TB] FAIL %s c_out: got %b expected %b", name, c_out, exp_c);
    else passed++;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    total++;
    if (zero !== (exp_res == 32'h0))
      $display("[TB] FAIL %s zero: got %b expected %b", name, zero, (exp_res == 32'h0));
    else passed++;
`endif
    release_result();
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("[TB] FAIL %s return_idle: got in_ready/out_valid %b expected 10", name, {in_ready, out_valid});
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'h0; b = 32'h0; alu_op = 3'b000;
    #23 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, c_out} !== 3'b100)
      $display("[TB] FAIL reset_flags: got in_ready/out_valid/c_out %b expected 100", {in_ready, out_valid, c_out});
    else passed++;
    total++;
    if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    else passed++;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    total++;
    if (zero !== 1'b1) $display("[TB] FAIL reset_zero: got %b expected 1", zero);
    else passed++;
`endif
  endtask

  task automatic test_arith();
    check_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1);
    check_op("sub_neg",  32'd5,        32'd7,        3'b110, 32'hFFFFFFFE, 1'b0);
    check_op("sub_eq",   32'h55,       32'h55,       3'b110, 32'h00000000, 1'b1);
  endtask

  task automatic test_logic();
    check_op("and",  32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b1);
    check_op("or",   32'h12340000, 32'h00005678, 3'b001, 32'h12345678, 1'b0);
    check_op("andn", 32'hFFFF0000, 32'h0F0F0F0F, 3'b100, 32'hF0F00000, 1'b1);
  endtask

  task automatic test_slt();
    check_op("slt_small", 32'd3,        32'd9,        3'b111, 32'h00000001, 1'b0);
    check_op("slt_ovf",   32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 32'h00000001, 1'b0);
    check_op("slt_ge",    32'd9,        32'd3,        3'b111, 32'h00000000, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic busy_rdy;
    int held_bad;
    run_op(32'h0000_1000, 32'h0000_0234, 3'b010, lat, busy_rdy);
    total++;
    if (lat !== 32) $display("[TB] FAIL bp_latency: got %0d expected 32", lat);
    else passed++;
    held_bad = 0;
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111; alu_op = 3'b001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== 32'h0000_1234 || c_out !== 1'b0) held_bad++;
    end
    total++;
    if (held_bad !== 0) $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", held_bad);
    else passed++;
    in_valid = 1'b0;
    release_result();
    total++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("[TB] FAIL bp_release: got in_ready/out_valid %b expected 10", {in_ready, out_valid});
    else passed++;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_no_accept: got in_ready %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    check_op("b2b_first",  32'h0000_00FF, 32'h0000_0001, 3'b010, 32'h0000_0100, 1'b0);
    out_ready = 1'b1;
    check_op("b2b_second", 32'h8000_0000, 32'h8000_0000, 3'b010, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    logic saw_valid;
    @(negedge clk);
    a = 32'hAAAA_5555; b = 32'h1234_5678; alu_op = 3'b010; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, c_out} !== 3'b100)
      $display("[TB] FAIL midrst_flags: got in_ready/out_valid/c_out %b expected 100", {in_ready, out_valid, c_out});
    else passed++;
    total++;
    if (result !== 32'h0) $display("[TB] FAIL midrst_result: got %h expected 00000000", result);
    else passed++;
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    #3 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    total++;
    if (saw_valid !== 1'b0) $display("[TB] FAIL midrst_no_valid: got %b expected 0", saw_valid);
    else passed++;
    check_op("after_rst", 32'h0000_FFFF, 32'h0000_0001, 3'b010, 32'h0001_0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_slt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Port clk, input, 1: clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port in_valid, input, 1: request present.
REQ-005 Port in_ready, output, 1: block can accept a request.
REQ-006 Port a, input, 32: operand A.
REQ-007 Port b, input, 32: operand B.
REQ-008 Port alu_op, input, 3: operation; bit 2 = invert B and carry-in 1, bits 1:0 = select (00 AND, 01 OR, 10 SUM, 11 LESS).
REQ-009 Port out_valid, output, 1: result present.
REQ-010 Port out_ready, input, 1: consumer takes result.
REQ-011 Port result, output, 32: operation result.
REQ-012 Port c_out, output, 1: carry out of bit 31.
REQ-013 Port zero, output, 1: result == 0; present only with ZERO_FLAG_EN.

Function
REQ-014 The block SHALL implement states IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, in_valid=1 at an edge SHALL capture a, b, alu_op, clear the 5-bit bit counter, set carry to alu_op[2], and enter BUSY.
REQ-017 In BUSY, each edge SHALL process exactly one bit i (LSB first, i = counter): bb = b[i] XOR alu_op[2]; g = a[i]&bb; p = a[i]|bb; s = a[i]^bb^carry; carry <= g | (p&carry).
REQ-018 Bit result SHALL be g for select 00, p for 01, s for 10, 0 for 11; it SHALL be written to result bit i.
REQ-019 After bit 31 is processed (32nd BUSY edge), the block SHALL enter DONE; c_out SHALL hold the final carry.
REQ-020 For select 11, result[0] SHALL equal s of bit 31 (no overflow correction); result[31:1] SHALL be 0.
REQ-021 out_valid SHALL rise exactly 32 cycles after the accepting edge; result, c_out, zero SHALL be stable while out_valid=1.
REQ-022 In DONE, out_ready=1 at an edge SHALL return to IDLE; the next request is acceptable no earlier than the following edge.
REQ-023 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE; operand inputs SHALL be don't-care after capture.
REQ-024 Counter SHALL not wrap: transition to DONE occurs at count 31, counter cleared on next accept.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, counter 0, carry 0, result 0, c_out 0, out_valid 0, in_ready 1 (after release), zero 1 when compiled in.
REQ-026 Reset during BUSY or DONE SHALL abort the operation with no out_valid pulse.
REQ-027 First accept after release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-028 Macro SERIAL_ALU_ZERO_FLAG_EN defined: zero port exists and equals (result == 32'h0), registered on DONE entry.
REQ-029 Macro SERIAL_ALU_ZERO_FLAG_EN undefined: zero port and its logic absent; all other behaviour identical.

Verification
REQ-030 ADD: a=0xFFFFFFFF, b=0x00000001, op=010 -> out_valid 32 cycles after accept, result=0x00000000, c_out=1, zero=1.
REQ-031 SUB: a=5, b=7, op=110 -> result=0xFFFFFFFE, c_out=0; AND a=0xF0F0F0F0, b=0xFF00FF00, op=000 -> 0xF000F000.
REQ-032 SLT: a=3, b=9, op=111 -> result=1; a=0x7FFFFFFF, b=0xFFFFFFFF, op=111 -> result=1 (sum-bit-31 rule, overflow uncorrected).
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, result held; in_valid=1 with new operands ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-034 Reset mid-op: rst_n=0 at bit 15 of BUSY -> all outputs reset values immediately; no out_valid; next request after release completes correctly.
